// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, default framing parameters and
// the mid-bit vote phases, kept here so the transmitter can reuse them.
package uart_pkg;

    localparam int OSR_DEFAULT       = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    localparam int VOTE_PH_A = 7;
    localparam int VOTE_PH_B = 8;
    localparam int VOTE_PH_C = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterized reset value so an idle-high line reads idle out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: start-edge detect, 3-sample majority vote
// at mid-bit, LSB-first shift, stop-bit check with break hold-off.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OSR       = OSR_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_ready,
    output logic                 frame_err
);

    localparam int CW = $clog2(OSR);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] PH_A    = CW'(VOTE_PH_A);
    localparam logic [CW-1:0] PH_B    = CW'(VOTE_PH_B);
    localparam logic [CW-1:0] PH_C    = CW'(VOTE_PH_C);
    localparam logic [CW-1:0] PH_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0] PH_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_END = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    logic                 rxd_s;
    uart_state_e          state_r;
    logic [CW-1:0]        phase_r;
    logic [IW-1:0]        bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] dout_r;
    logic [1:0]           sample_r;
    logic                 rx_ready_r;
    logic                 frame_err_r;
    logic                 voted_s;
    logic                 bit_end_s;
    logic                 vote_now_s;
    logic [CW-1:0]        phase_next_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (bclk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // The third vote sample is the live synchronized line at phase 9.
    assign voted_s      = majority3(sample_r[0], sample_r[1], rxd_s);
    assign bit_end_s    = (phase_r == PH_LAST);
    assign vote_now_s   = (phase_r == PH_C);
    assign phase_next_s = bit_end_s ? {CW{1'b0}} : (phase_r + PH_ONE);

    // Receiver FSM with registered data and single-cycle status pulses.
    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            phase_r     <= {CW{1'b0}};
            bit_idx_r   <= {IW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            dout_r      <= {DATA_BITS{1'b0}};
            sample_r    <= 2'b00;
            rx_ready_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_ready_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (phase_r == PH_A) begin
                sample_r[0] <= rxd_s;
            end else if (phase_r == PH_B) begin
                sample_r[1] <= rxd_s;
            end else begin
                sample_r <= sample_r;
            end

            case (state_r)
                ST_IDLE: begin
                    phase_r   <= {CW{1'b0}};
                    bit_idx_r <= {IW{1'b0}};
                    if (!rxd_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    phase_r <= phase_next_s;
                    if (vote_now_s && voted_s) begin
                        state_r <= ST_IDLE;
                        phase_r <= {CW{1'b0}};
                    end else if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= {IW{1'b0}};
                    end
                end
                ST_DATA: begin
                    phase_r <= phase_next_s;
                    if (vote_now_s) begin
                        shift_r <= {voted_s, shift_r[DATA_BITS-1:1]};
                    end
                    if (bit_end_s) begin
                        if (bit_idx_r == IDX_END) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    phase_r <= phase_next_s;
                    if (vote_now_s) begin
                        phase_r   <= {CW{1'b0}};
                        bit_idx_r <= {IW{1'b0}};
                        if (voted_s) begin
                            dout_r     <= shift_r;
                            rx_ready_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    phase_r <= {CW{1'b0}};
                    if (rxd_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign dout      = dout_r;
    assign rx_ready  = rx_ready_r;
    assign frame_err = frame_err_r;

endmodule
